// File: rtl/vr_stream_port_pkg.sv
// Shared types for the VR stream port.
// FSM states, transfer directions and sizing helpers.
package vr_stream_port_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic DIR_RD = 1'b0;
    localparam logic DIR_WR = 1'b1;

    function automatic int cnt_wth(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/vr_stream_port_if.sv
// Valid/ready beat stream carrying one VR entry per beat.
// The master drives data/valid/last, the slave drives ready.
interface vr_stream_port_if
    import vr_stream_port_pkg::*;
#(
    parameter int DATA_WTH = 2048
);
    logic [DATA_WTH-1:0] data;
    logic                valid;
    logic                last;
    logic                ready;

    modport master (
        output data,
        output valid,
        output last,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  last,
        output ready
    );
endinterface

// File: rtl/vr_stream_port_rd_fifo.sv
// Read-return buffer between the VR read port and the stream.
// Registered head, occupancy count, async active-low reset.
module vr_stream_port_rd_fifo
    import vr_stream_port_pkg::*;
#(
    parameter int WIDTH = 2048,
    parameter int DEPTH = 3,
    parameter int CW    = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt_q;

    function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage, pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ptr_nxt(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_nxt(rd_ptr);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!push && pop) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign rdata = mem[rd_ptr];
    assign count = cnt_q;

    a_no_overflow: assert property (
        @(posedge clk_i) disable iff (!rst_n_i)
        !(push && !pop && cnt_q == CW'(DEPTH))
    );

    a_no_underflow: assert property (
        @(posedge clk_i) disable iff (!rst_n_i)
        !(pop && cnt_q == '0)
    );

endmodule

// File: rtl/vr_stream_port.sv
// Command-driven bulk mover between the VR port and two streams.
// Dir 0 streams VR entries out; dir 1 writes stream beats into VR.
module vr_stream_port
    import vr_stream_port_pkg::*;
#(
    parameter int VR_IND_WTH   = 4,
    parameter int VR_DATA_WTH  = 2048,
    parameter int RD_BUF_DEPTH = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic                   cmd_dir_i,
    input  logic [VR_IND_WTH-1:0]  cmd_base_i,
    input  logic [VR_IND_WTH-1:0]  cmd_len_i,
    output logic [VR_IND_WTH-1:0]  vr_rindex_o,
    output logic                   vr_re_o,
    input  logic [VR_DATA_WTH-1:0] vr_rdata_i,
    input  logic                   vr_rdata_act_i,
    output logic [VR_IND_WTH-1:0]  vr_windex_o,
    output logic                   vr_we_o,
    output logic [VR_DATA_WTH-1:0] vr_wdata_o,
    vr_stream_port_if.master       m,
    vr_stream_port_if.slave        s,
    output logic                   done_o,
    output logic                   done_err_o
);
    localparam int W  = VR_IND_WTH;
    localparam int CW = cnt_wth(RD_BUF_DEPTH);

    state_e state_q;
    state_e state_d;

    logic [W-1:0]           base_q;
    logic [W-1:0]           len_q;
    logic [W:0]             iss_q;
    logic [W:0]             beat_q;
    logic                   err_q;
    logic                   re_q;
    logic                   inflight_q;
    logic [W-1:0]           rindex_q;
    logic                   we_q;
    logic [W-1:0]           windex_q;
    logic [VR_DATA_WTH-1:0] wdata_q;

    logic [CW-1:0]          buf_count;
    logic [VR_DATA_WTH-1:0] buf_head;

    logic                   cmd_hs;
    logic                   m_hs;
    logic                   s_hs;
    logic                   push;
    logic                   issue;
    logic [W-1:0]           issue_idx;
    logic                   last_beat;
    logic                   iss_left;
    logic                   room;
    logic [CW:0]            occ;

    vr_stream_port_rd_fifo #(
        .WIDTH (VR_DATA_WTH),
        .DEPTH (RD_BUF_DEPTH),
        .CW    (CW)
    ) u_rd_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push    (push),
        .wdata   (vr_rdata_i),
        .pop     (m_hs),
        .rdata   (buf_head),
        .count   (buf_count)
    );

    assign cmd_hs    = cmd_valid_i && (state_q == ST_IDLE);
    assign last_beat = (beat_q == {1'b0, len_q});
    assign iss_left  = (iss_q <= {1'b0, len_q});

    assign m.valid = (buf_count != '0);
    assign m.data  = buf_head;
    assign m.last  = m.valid && last_beat;
    assign m_hs    = m.valid && m.ready;

    assign s.ready = (state_q == ST_WR) && (beat_q <= {1'b0, len_q});
    assign s_hs    = s.valid && s.ready;

    // Acts only count when a read was actually issued the cycle before.
    assign push = vr_rdata_act_i && inflight_q;

    // A beat leaving this cycle frees its slot for a read issued now.
    assign occ  = (CW+1)'(buf_count) + (CW+1)'(re_q)
                + (CW+1)'(inflight_q) - (CW+1)'(m_hs);
    assign room = (occ < (CW+1)'(RD_BUF_DEPTH));

    // Next state, read issue decision and status outputs
    always_comb begin
        state_d     = state_q;
        issue       = 1'b0;
        issue_idx   = base_q + iss_q[W-1:0];
        cmd_ready_o = 1'b0;
        done_o      = 1'b0;
        done_err_o  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    if (cmd_dir_i == DIR_WR) begin
                        state_d = ST_WR;
                    end else begin
                        state_d   = ST_RD;
                        issue     = 1'b1;
                        issue_idx = cmd_base_i;
                    end
                end
            end
            ST_RD: begin
                issue = iss_left && room;
                if (m_hs && last_beat) begin
                    state_d = ST_DONE;
                end
            end
            ST_WR: begin
                if (s_hs && last_beat) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o     = 1'b1;
                done_err_o = err_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command capture, issue/beat counters and last-marker error
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            base_q <= '0;
            len_q  <= '0;
            iss_q  <= '0;
            beat_q <= '0;
            err_q  <= 1'b0;
        end else if (cmd_hs) begin
            base_q <= cmd_base_i;
            len_q  <= cmd_len_i;
            beat_q <= '0;
            err_q  <= 1'b0;
            iss_q  <= (cmd_dir_i == DIR_RD) ? (W+1)'(1) : '0;
        end else begin
            if (issue) begin
                iss_q <= iss_q + 1'b1;
            end
            if (m_hs || s_hs) begin
                beat_q <= beat_q + 1'b1;
            end
            if (s_hs && (s.last != last_beat)) begin
                err_q <= 1'b1;
            end
        end
    end

    // VR read request register and one-cycle return tracking
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            re_q       <= 1'b0;
            rindex_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            re_q       <= issue;
            inflight_q <= re_q;
            if (issue) begin
                rindex_q <= issue_idx;
            end
        end
    end

    // VR write port registers, one per accepted stream beat
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            we_q     <= 1'b0;
            windex_q <= '0;
            wdata_q  <= '0;
        end else begin
            we_q <= s_hs;
            if (s_hs) begin
                windex_q <= base_q + beat_q[W-1:0];
                wdata_q  <= s.data;
            end
        end
    end

    assign vr_re_o     = re_q;
    assign vr_rindex_o = rindex_q;
    assign vr_we_o     = we_q;
    assign vr_windex_o = windex_q;
    assign vr_wdata_o  = wdata_q;

endmodule

// File: tb/tb_vr_stream_port.sv
// Bench for vr_stream_port: VR responder plus scenario tasks.
// Expected beats and writes come from a simple index/data model.
module tb_vr_stream_port;
    localparam int DW    = 2048;
    localparam int DEPTH = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_dir;
    logic [3:0]    cmd_base;
    logic [3:0]    cmd_len;
    logic [3:0]    vr_rindex;
    logic          vr_re;
    logic [DW-1:0] rdata_r;
    logic          act_r;
    logic          inj_act;
    logic [3:0]    vr_windex;
    logic          vr_we;
    logic [DW-1:0] vr_wdata;
    logic          done;
    logic          done_err;

    logic [DW-1:0] vrmem [16];

    int total  = 0;
    int passed = 0;

    vr_stream_port_if #(.DATA_WTH(DW)) m_if ();
    vr_stream_port_if #(.DATA_WTH(DW)) s_if ();

    vr_stream_port #(
        .VR_IND_WTH   (4),
        .VR_DATA_WTH  (DW),
        .RD_BUF_DEPTH (DEPTH)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .cmd_valid_i    (cmd_valid),
        .cmd_ready_o    (cmd_ready),
        .cmd_dir_i      (cmd_dir),
        .cmd_base_i     (cmd_base),
        .cmd_len_i      (cmd_len),
        .vr_rindex_o    (vr_rindex),
        .vr_re_o        (vr_re),
        .vr_rdata_i     (rdata_r),
        .vr_rdata_act_i (act_r | inj_act),
        .vr_windex_o    (vr_windex),
        .vr_we_o        (vr_we),
        .vr_wdata_o     (vr_wdata),
        .m              (m_if.master),
        .s              (s_if.slave),
        .done_o         (done),
        .done_err_o     (done_err)
    );

    always #5 clk = ~clk;

    // VR model: read data and act one cycle after the read enable
    always @(posedge clk) begin
        act_r   <= vr_re;
        rdata_r <= vrmem[vr_rindex];
    end

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) begin
            d[i*32 +: 32] = $urandom;
        end
        return d;
    endfunction

    task automatic run_rd(input int base, input int len, input int mode,
                          input int stall, input bit timed);
        logic [DW-1:0] exp_q [$];
        logic [DW-1:0] e;
        logic [DW-1:0] held;
        logic [3:0]    ei;
        int  n_iss;
        int  n_pop;
        int  cyc;
        bit  fin;
        bit  hold;
        for (int k = 0; k <= len; k++) begin
            exp_q.push_back(vrmem[(base + k) % 16]);
        end
        n_iss = 0;
        n_pop = 0;
        fin   = 1'b0;
        hold  = 1'b0;
        held  = '0;
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1) begin
            $display("FAIL rd_cmd_ready got=%b exp=1", cmd_ready);
        end else passed++;
        cmd_valid = 1'b1;
        cmd_dir   = 1'b0;
        cmd_base  = 4'(base);
        cmd_len   = 4'(len);
        for (cyc = 1; cyc <= 400 && !fin; cyc++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (vr_re) begin
                ei = 4'((base + n_iss) % 16);
                total++;
                if (vr_rindex !== ei || n_iss > len) begin
                    $display("FAIL rd_index n=%0d got=%0d exp=%0d", n_iss, vr_rindex, ei);
                end else passed++;
                if (timed && n_iss == 0) begin
                    total++;
                    if (cyc != 1) begin
                        $display("FAIL rd_re_latency got=%0d exp=1", cyc);
                    end else passed++;
                end
                n_iss++;
                total++;
                if (n_iss - n_pop > DEPTH) begin
                    $display("FAIL rd_outstanding got=%0d exp<=%0d", n_iss - n_pop, DEPTH);
                end else passed++;
            end
            if (hold) begin
                total++;
                if (m_if.valid !== 1'b1 || m_if.data !== held) begin
                    $display("FAIL rd_hold got=%h exp=%h", m_if.data[63:0], held[63:0]);
                end else passed++;
            end
            if (cyc <= stall) m_if.ready = 1'b0;
            else if (mode == 0) m_if.ready = 1'b1;
            else if (mode == 1) m_if.ready = (cyc % 2 == 1);
            else m_if.ready = 1'($urandom % 2);
            if (m_if.valid && m_if.ready) begin
                e = (n_pop <= len) ? exp_q[n_pop] : '0;
                total++;
                if (n_pop > len || m_if.data !== e) begin
                    $display("FAIL rd_data beat=%0d got=%h exp=%h", n_pop, m_if.data[63:0], e[63:0]);
                end else passed++;
                total++;
                if (m_if.last !== (n_pop == len)) begin
                    $display("FAIL rd_last beat=%0d got=%b exp=%b", n_pop, m_if.last, n_pop == len);
                end else passed++;
                if (timed) begin
                    total++;
                    if (cyc != 3 + n_pop) begin
                        $display("FAIL rd_beat_cycle beat=%0d got=%0d exp=%0d", n_pop, cyc, 3 + n_pop);
                    end else passed++;
                end
                n_pop++;
            end
            hold = m_if.valid && !m_if.ready;
            held = m_if.data;
            if (done) begin
                total++;
                if (n_pop != len + 1 || done_err !== 1'b0) begin
                    $display("FAIL rd_done beats=%0d exp=%0d err=%b", n_pop, len + 1, done_err);
                end else passed++;
                if (timed) begin
                    total++;
                    if (cyc != 4 + len) begin
                        $display("FAIL rd_done_cycle got=%0d exp=%0d", cyc, 4 + len);
                    end else passed++;
                end
                fin = 1'b1;
            end
        end
        m_if.ready = 1'b0;
        total++;
        if (!fin) begin
            $display("FAIL rd_timeout beats=%0d exp=%0d", n_pop, len + 1);
        end else passed++;
        @(negedge clk);
        total++;
        if (done !== 1'b0 || cmd_ready !== 1'b1) begin
            $display("FAIL rd_after_done done=%b ready=%b exp=0,1", done, cmd_ready);
        end else passed++;
    endtask

    task automatic run_wr(input int base, input int len, input int last_at,
                          input bit rnd);
        logic [DW-1:0] beats [16];
        logic [DW-1:0] e;
        logic [3:0]    ei;
        int  n_acc;
        int  cyc;
        bit  exp_err;
        bit  fin;
        bit  prev_hs;
        exp_err = 1'b0;
        for (int k = 0; k <= len; k++) begin
            beats[k] = rand_data();
            if ((k == last_at) != (k == len)) exp_err = 1'b1;
        end
        n_acc   = 0;
        fin     = 1'b0;
        prev_hs = 1'b0;
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1) begin
            $display("FAIL wr_cmd_ready got=%b exp=1", cmd_ready);
        end else passed++;
        cmd_valid = 1'b1;
        cmd_dir   = 1'b1;
        cmd_base  = 4'(base);
        cmd_len   = 4'(len);
        for (cyc = 1; cyc <= 400 && !fin; cyc++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            total++;
            if (vr_we !== prev_hs) begin
                $display("FAIL wr_we cyc=%0d got=%b exp=%b", cyc, vr_we, prev_hs);
            end else passed++;
            if (prev_hs) begin
                e  = beats[n_acc-1];
                ei = 4'((base + n_acc - 1) % 16);
                total++;
                if (vr_windex !== ei || vr_wdata !== e) begin
                    $display("FAIL wr_beat n=%0d idx=%0d exp=%0d data=%h exp=%h",
                             n_acc - 1, vr_windex, ei, vr_wdata[63:0], e[63:0]);
                end else passed++;
            end
            total++;
            if (s_if.ready !== (n_acc <= len)) begin
                $display("FAIL wr_s_ready n=%0d got=%b exp=%b", n_acc, s_if.ready, n_acc <= len);
            end else passed++;
            if (done) begin
                total++;
                if (n_acc != len + 1 || done_err !== exp_err) begin
                    $display("FAIL wr_done beats=%0d exp=%0d err=%b exp=%b",
                             n_acc, len + 1, done_err, exp_err);
                end else passed++;
                fin = 1'b1;
            end
            if (n_acc <= len && !fin) begin
                s_if.valid = rnd ? 1'($urandom % 2) : 1'b1;
                s_if.data  = beats[n_acc];
                s_if.last  = (n_acc == last_at);
            end else begin
                s_if.valid = 1'b0;
                s_if.last  = 1'b0;
            end
            prev_hs = s_if.valid && s_if.ready;
            if (prev_hs) n_acc++;
        end
        s_if.valid = 1'b0;
        total++;
        if (!fin) begin
            $display("FAIL wr_timeout beats=%0d exp=%0d", n_acc, len + 1);
        end else passed++;
        @(negedge clk);
        total++;
        if (done !== 1'b0 || done_err !== 1'b0 || cmd_ready !== 1'b1) begin
            $display("FAIL wr_after_done done=%b err=%b ready=%b", done, done_err, cmd_ready);
        end else passed++;
    endtask

    task automatic test_reset();
        logic [7:0] flags;
        rst_n = 1'b0;
        @(negedge clk);
        flags = {cmd_ready, vr_re, vr_we, m_if.valid, m_if.last, s_if.ready, done, done_err};
        total++;
        if (flags !== 8'b1000_0000) begin
            $display("FAIL reset_flags got=%b exp=10000000", flags);
        end else passed++;
        total++;
        if ({vr_rindex, vr_windex} !== 8'h00 || vr_wdata !== '0 || m_if.data !== '0) begin
            $display("FAIL reset_data ri=%0d wi=%0d", vr_rindex, vr_windex);
        end else passed++;
        rst_n = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_dir   = 1'b0;
        cmd_base  = 4'd0;
        cmd_len   = 4'd7;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (m_if.valid !== 1'b1) begin
            $display("FAIL reset_pre_fill got=%b exp=1", m_if.valid);
        end else passed++;
        rst_n = 1'b0;
        #1;
        flags = {cmd_ready, vr_re, vr_we, m_if.valid, m_if.last, s_if.ready, done, done_err};
        total++;
        if (flags !== 8'b1000_0000) begin
            $display("FAIL reset_mid_flags got=%b exp=10000000", flags);
        end else passed++;
        total++;
        if (m_if.data !== '0 || vr_rindex !== 4'd0) begin
            $display("FAIL reset_mid_data got=%h ri=%0d", m_if.data[63:0], vr_rindex);
        end else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        inj_act = 1'b1;
        @(negedge clk);
        inj_act = 1'b0;
        flags = {cmd_ready, vr_re, vr_we, m_if.valid, m_if.last, s_if.ready, done, done_err};
        total++;
        if (flags !== 8'b1000_0000) begin
            $display("FAIL reset_stale_act got=%b exp=10000000", flags);
        end else passed++;
        run_rd(3, 2, 0, 0, 1'b1);
    endtask

    task automatic test_rd_basic();
        for (int i = 0; i < 16; i++) vrmem[i] = DW'(i * 17);
        run_rd(2, 3, 0, 0, 1'b1);
    endtask

    task automatic test_rd_wrap_toggle();
        for (int i = 0; i < 16; i++) vrmem[i] = rand_data();
        run_rd(14, 3, 1, 0, 1'b0);
    endtask

    task automatic test_wr_basic();
        run_wr(5, 1, 1, 1'b0);
    endtask

    task automatic test_wr_err();
        run_wr(9, 2, 0, 1'b0);
        run_wr(0, 0, 0, 1'b0);
    endtask

    task automatic test_rd_full_stall();
        run_rd(int'($urandom_range(0, 15)), 15, 0, 20, 1'b0);
    endtask

    task automatic test_random();
        int len;
        for (int t = 0; t < 8; t++) begin
            len = int'($urandom_range(0, 15));
            if ($urandom % 2 == 0) begin
                run_rd(int'($urandom_range(0, 15)), len, 2,
                       int'($urandom_range(0, 5)), 1'b0);
            end else begin
                run_wr(int'($urandom_range(0, 15)), len,
                       ($urandom % 2 == 0) ? len : int'($urandom_range(0, 15)), 1'b1);
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_dir    = 1'b0;
        cmd_base   = '0;
        cmd_len    = '0;
        inj_act    = 1'b0;
        m_if.ready = 1'b0;
        s_if.valid = 1'b0;
        s_if.last  = 1'b0;
        s_if.data  = '0;
        for (int i = 0; i < 16; i++) vrmem[i] = rand_data();
        test_reset();
        test_rd_basic();
        test_rd_wrap_toggle();
        test_wr_basic();
        test_wr_err();
        test_rd_full_stall();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
